// File: rtl/store_merge_unit_pkg.sv
// Shared definitions for the store merge unit.
// - byte_sel encodings, identical to the load extend unit's
// - FSM state encoding for the read-modify-write sequencer
// - req_invalid(): alignment / reserved-encoding check on a store request
package store_merge_unit_pkg;

  typedef enum logic [1:0] {
    SEL_BYTE = 2'b00,
    SEL_HALF = 2'b01,
    SEL_RSVD = 2'b10,
    SEL_WORD = 2'b11
  } byte_sel_e;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    ERR
  } state_e;

  // Width of the read-wait counter; covers TIMEOUT up to 255.
  localparam int unsigned CNT_W = 8;

  // Halfwords must be 2-byte aligned, words 4-byte aligned, and the
  // reserved encoding is always rejected.
  function automatic logic req_invalid(input logic [1:0] sel,
                                       input logic [1:0] offset);
    case (sel)
      SEL_HALF: return offset[0];
      SEL_WORD: return offset != 2'b00;
      SEL_RSVD: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_merge_unit_lane_merge.sv
// store_lane_merge: combinational lane insertion for partial stores.
// Ports:
//   old_word [31:0]  word read back from memory
//   new_data [31:0]  right-justified store data
//   sel      [1:0]   byte_sel encoding (byte / half / word)
//   offset   [1:0]   byte offset within the word
//   merged   [31:0]  old_word with the addressed lane replaced
// Little-endian: byte lane k is [8k+7:8k]; halfword at offset 2 is [31:16].
module store_lane_merge
  import store_merge_unit_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  sel,
  input  logic [1:0]  offset,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    case (sel)
      SEL_BYTE: merged[{offset, 3'b000} +: 8] = new_data[7:0];
      SEL_HALF: begin
        if (offset[1]) merged[31:16] = new_data[15:0];
        else           merged[15:0]  = new_data[15:0];
      end
      SEL_WORD: merged = new_data;
      default:  merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_merge_unit.sv
// store_merge_unit: SB/SH/SW stores into a word-wide memory with no byte
// enables. Partial stores do read-modify-write; full words write directly.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   store request handshake (ready only in IDLE)
//   req_addr, req_data    byte address, right-justified store data
//   byte_sel              00 byte, 01 half, 11 word, 10 reserved
//   mem_addr              word address to data memory
//   mem_rd_en             one-cycle read strobe
//   mem_rd_data/valid     read return
//   mem_wr_en/wr_data     one-cycle write strobe and merged word
//   done, err             completion pulse; err marks an aborted store
module store_merge_unit
  import store_merge_unit_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        byte_sel,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rd_data,
  input  logic              mem_rd_valid,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_data,
  output logic              done,
  output logic              err
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      data_q;
  logic [1:0]       sel_q;
  logic [1:0]       off_q;
  logic [31:0]      merged;
  logic             bad_req;

  assign bad_req = req_invalid(byte_sel, req_addr[1:0]);

  store_lane_merge u_merge (
    .old_word (mem_rd_data),
    .new_data (data_q),
    .sel      (sel_q),
    .offset   (off_q),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (bad_req)                  state_d = ERR;
          else if (byte_sel == SEL_WORD) state_d = WRITE;
          else                          state_d = READ;
        end
      end
      READ: begin
        mem_rd_en = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        // A valid arriving on the limit cycle still completes the store.
        if (mem_rd_valid)                          state_d = WRITE;
        else if (cnt_q == CNT_W'(TIMEOUT - 1))     state_d = ERR;
      end
      WRITE: begin
        mem_wr_en = 1'b1;
        done      = 1'b1;
        state_d   = IDLE;
      end
      ERR: begin
        done    = 1'b1;
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr    <= '0;
      mem_wr_data <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      sel_q       <= '0;
      off_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            mem_addr <= req_addr[ADDR_W-1:2];
            data_q   <= req_data;
            sel_q    <= byte_sel;
            off_q    <= req_addr[1:0];
            if (byte_sel == SEL_WORD && !bad_req) mem_wr_data <= req_data;
          end
        end
        READ: cnt_q <= '0;
        WAIT: begin
          if (mem_rd_valid) mem_wr_data <= merged;
          else              cnt_q       <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_store_merge_unit.sv
module tb_store_merge_unit;

  localparam int unsigned TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  byte_sel;
  logic [29:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rd_data;
  logic        mem_rd_valid;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  // Memory responder: returns rd_word rd_lat cycles after a read strobe
  // (rd_lat = 0 means never respond). force_valid injects a stray valid.
  int          rd_lat = 0;
  logic [31:0] rd_word = '0;
  logic        force_valid = 1'b0;
  int          pend = 0;

  always @(posedge clk) begin
    if (mem_rd_en && rd_lat > 0) pend <= rd_lat;
    else if (pend != 0)          pend <= pend - 1;
  end

  assign mem_rd_valid = (pend == 1) || force_valid;
  assign mem_rd_data  = rd_word;

  always #5 clk = ~clk;

  store_merge_unit #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .byte_sel     (byte_sel),
    .mem_addr     (mem_addr),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_valid (mem_rd_valid),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_data  (mem_wr_data),
    .done         (done),
    .err          (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one store; the accept cycle is numbered 1.
  task automatic run_store(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] sel, input int lat, input logic [31:0] word,
                           output int done_cyc, output int rd_cnt, output int wr_cnt,
                           output logic [31:0] wr_data, output logic [29:0] done_addr,
                           output logic err_seen);
    int cyc;
    done_cyc = 0; rd_cnt = 0; wr_cnt = 0; wr_data = '0; done_addr = '0; err_seen = 1'b0;
    rd_lat = lat; rd_word = word;
    req_valid = 1'b1; req_addr = addr; req_data = data; byte_sel = sel;
    chk("ready_at_accept", {31'd0, req_ready}, 32'd1);
    cyc = 1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc++;
      if (mem_rd_en) rd_cnt++;
      if (mem_wr_en) begin wr_cnt++; wr_data = mem_wr_data; end
      if (done) begin
        done_cyc = cyc; err_seen = err; done_addr = mem_addr;
        break;
      end
      step();
    end
    step();
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  sel;
    int          lat;
    logic [31:0] word;
    logic [31:0] exp_wr;
    logic        exp_err;
    int          exp_done;
    int          exp_rd;
    int          exp_wrn;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int          dc, rc, wc;
    logic [31:0] wd;
    logic [29:0] da;
    logic        es;
    int          acc_cyc[2];
    int          done_cyc[2];
    logic [31:0] wr_val[2];
    int          n_acc, n_done, n_wr;

    vecs[0]  = '{"sb_off1",     32'h1001, 32'h000000AB, 2'b00, 1,  32'h11223344, 32'h1122AB44, 1'b0, 4, 1, 1};
    vecs[1]  = '{"sh_off2",     32'h2002, 32'h0000BEEF, 2'b01, 3,  32'hCAFEF00D, 32'hBEEFF00D, 1'b0, 6, 1, 1};
    vecs[2]  = '{"sw",          32'h2004, 32'hDEADBEEF, 2'b11, 1,  32'h00000000, 32'hDEADBEEF, 1'b0, 2, 0, 1};
    vecs[3]  = '{"sh_misalign", 32'h3001, 32'h00001234, 2'b01, 1,  32'h55555555, 32'h0,        1'b1, 2, 0, 0};
    vecs[4]  = '{"sw_misalign", 32'h3002, 32'h12345678, 2'b11, 1,  32'h55555555, 32'h0,        1'b1, 2, 0, 0};
    vecs[5]  = '{"sel_rsvd",    32'h3000, 32'h12345678, 2'b10, 1,  32'h55555555, 32'h0,        1'b1, 2, 0, 0};
    vecs[6]  = '{"sb_off3",     32'h4003, 32'hFFFFFF5A, 2'b00, 2,  32'h01020304, 32'h5A020304, 1'b0, 5, 1, 1};
    vecs[7]  = '{"sb_off0",     32'h4000, 32'h00000077, 2'b00, 1,  32'hAABBCCDD, 32'hAABBCC77, 1'b0, 4, 1, 1};
    vecs[8]  = '{"sh_off0",     32'h4000, 32'hFFFF9876, 2'b01, 1,  32'h11223344, 32'h11229876, 1'b0, 4, 1, 1};
    vecs[9]  = '{"sb_timeout",  32'h5002, 32'h000000C3, 2'b00, 0,  32'h00000000, 32'h0,        1'b1, 3 + TIMEOUT, 1, 0};
    vecs[10] = '{"sb_lastwait", 32'h5002, 32'h000000C3, 2'b00, TIMEOUT, 32'h00000000, 32'h00C30000, 1'b0, 3 + TIMEOUT, 1, 1};

    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; byte_sel = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_ready",   {31'd0, req_ready}, 32'd1);
    chk("rst_addr",    {2'b00, mem_addr}, 32'd0);
    chk("rst_wr_data", mem_wr_data, 32'd0);
    chk("rst_strobes", {28'd0, mem_rd_en, mem_wr_en, done, err}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      run_store(vecs[i].addr, vecs[i].data, vecs[i].sel, vecs[i].lat, vecs[i].word,
                dc, rc, wc, wd, da, es);
      chk({vecs[i].name, "_done_cyc"}, dc, vecs[i].exp_done);
      chk({vecs[i].name, "_err"}, {31'd0, es}, {31'd0, vecs[i].exp_err});
      chk({vecs[i].name, "_rd_cnt"}, rc, vecs[i].exp_rd);
      chk({vecs[i].name, "_wr_cnt"}, wc, vecs[i].exp_wrn);
      chk({vecs[i].name, "_addr"}, {2'b00, da}, {2'b00, vecs[i].addr[31:2]});
      if (vecs[i].exp_wrn != 0) chk({vecs[i].name, "_wr_data"}, wd, vecs[i].exp_wr);
    end

    // Reset while waiting for read data; a late valid must be ignored.
    rd_lat = 0; rd_word = 32'hFFFFFFFF;
    req_valid = 1'b1; req_addr = 32'h6001; req_data = 32'h99; byte_sel = 2'b00;
    step();
    req_valid = 1'b0;
    step();
    chk("rst_mid_in_wait", {31'd0, req_ready}, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_strobes", {28'd0, mem_rd_en, mem_wr_en, done, err}, 32'd0);
    chk("rst_mid_addr", {2'b00, mem_addr}, 32'd0);
    force_valid = 1'b1;
    step();
    force_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_valid_ignored", {27'd0, req_ready, mem_rd_en, mem_wr_en, done, err}, 32'h10);
      step();
    end

    // Back-to-back: req_valid held across two byte stores into one word.
    rd_lat = 1; rd_word = 32'hA0B0C0D0;
    req_valid = 1'b1; req_addr = 32'h7000; req_data = 32'h11; byte_sel = 2'b00;
    n_acc = 0; n_done = 0; n_wr = 0;
    acc_cyc = '{0, 0}; done_cyc = '{0, 0}; wr_val = '{32'h0, 32'h0};
    for (int c = 0; c < 40 && n_wr < 2; c++) begin
      if (req_valid && req_ready && n_acc < 2) begin acc_cyc[n_acc] = c; n_acc++; end
      if (done && n_done < 2) begin done_cyc[n_done] = c; n_done++; end
      if (mem_wr_en) begin wr_val[n_wr] = mem_wr_data; rd_word = mem_wr_data; n_wr++; end
      step();
      if (n_acc == 1) begin req_addr = 32'h7002; req_data = 32'h22; end
      if (n_acc == 2) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    step();
    chk("b2b_writes", n_wr, 2);
    chk("b2b_second_accept", acc_cyc[1], done_cyc[0] + 1);
    chk("b2b_wr0", wr_val[0], 32'hA0B0C011);
    chk("b2b_wr1", wr_val[1], 32'hA022C011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
